m_sequence_despreader: RTL and testbench

Receive-side counterpart of the M-sequence generator. It samples a chip stream in which each chip is held for HOLD clock cycles. From the first LENGTH chips it recovers the generator's starting phase. It then runs a local LFSR replica over the remaining N-LENGTH chips and counts disagreements, and ends each frame with a lock decision.

---
 rtl/m_sequence_despreader.sv | 184 ++++++++++++++++++
 tb/tb_m_sequence_despreader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_sequence_despreader.sv
// m_sequence_despreader: recovers the start phase of an M-sequence chip stream, then checks the
// rest of the frame against a free-running LFSR replica and issues a lock decision per frame.
// Optional feature macro: DESPREAD_ERRCNT_EN adds err_cnt_o with the saturated mismatch count.
module m_sequence_despreader #(
  parameter int unsigned        N        = 63,
  parameter int unsigned        LENGTH   = $clog2(N),
  parameter logic [LENGTH-1:0]  POLYNOME = 6'b000011,
  parameter int unsigned        HOLD     = 3,
  parameter int unsigned        MAX_ERR  = 0
`ifdef DESPREAD_ERRCNT_EN
  ,
  localparam int unsigned       ERRW     = $clog2(N - LENGTH + 1)
`endif
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              chip_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              lock_o,
  output logic [LENGTH-1:0] phase_o,
  output logic              abort_o
`ifdef DESPREAD_ERRCNT_EN
  ,
  output logic [ERRW-1:0]   err_cnt_o
`endif
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned CW = $clog2(N);
`ifdef DESPREAD_ERRCNT_EN
  localparam int unsigned    CNTW = ERRW;
  localparam logic [CNTW-1:0] SAT = '1;
`else
  // Without the output only "more than MAX_ERR" matters, so count no further than MAX_ERR+1.
  localparam int unsigned    CNTW = $clog2(MAX_ERR + 2);
  localparam logic [CNTW-1:0] SAT = CNTW'(MAX_ERR + 1);
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StTrack} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [LENGTH-1:0] win_q, win_d;
  logic [LENGTH-1:0] ph_q, ph_d;
  logic [CW-1:0]     chip_cnt_q, chip_cnt_d;
  logic [CNTW-1:0]   err_q, err_d;
  logic [LENGTH-1:0] phase_q, phase_d;
  logic              lock_q, lock_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
`ifdef DESPREAD_ERRCNT_EN
  logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
`endif

  logic              sample;
  logic              pred;
  logic [CNTW-1:0]   err_nxt;

  // Chip sample strobe: first cycle of valid, then once every HOLD cycles.
  always_comb begin
    sample = valid_i && (hold_cnt_q == '0);
    if (!valid_i) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q == '0) begin
      hold_cnt_d = HW'(HOLD - 1);
    end else begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  // Frame FSM: load window, track replica, decide lock.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ph_d       = ph_q;
    chip_cnt_d = chip_cnt_q;
    err_d      = err_q;
    phase_d    = phase_q;
    lock_d     = lock_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
`ifdef DESPREAD_ERRCNT_EN
    err_cnt_d  = err_cnt_q;
`endif
    pred       = ^(POLYNOME & win_q);
    err_nxt    = err_q;
    if (pred != chip_i && err_q != SAT) begin
      err_nxt = err_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sample) begin
          win_d      = {chip_i, win_q[LENGTH-1:1]};
          chip_cnt_d = CW'(1);
          err_d      = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (!valid_i) begin
          abort_d = 1'b1;
          state_d = StIdle;
        end else if (sample) begin
          win_d      = {chip_i, win_q[LENGTH-1:1]};
          chip_cnt_d = chip_cnt_q + 1'b1;
          if (chip_cnt_q == CW'(LENGTH - 1)) begin
            ph_d    = {chip_i, win_q[LENGTH-1:1]};
            state_d = StTrack;
          end
        end
      end
      StTrack: begin
        if (!valid_i) begin
          abort_d = 1'b1;
          state_d = StIdle;
        end else if (sample) begin
          // Replica free-runs on its own prediction, never on received chips.
          win_d      = {pred, win_q[LENGTH-1:1]};
          err_d      = err_nxt;
          chip_cnt_d = chip_cnt_q + 1'b1;
          if (chip_cnt_q == CW'(N - 1)) begin
            done_d  = 1'b1;
            phase_d = ph_q;
            lock_d  = (32'(err_nxt) <= MAX_ERR) && (ph_q != '0);
`ifdef DESPREAD_ERRCNT_EN
            err_cnt_d = err_nxt;
`endif
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset acts immediately and discards a coincident sample.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      win_q      <= '0;
      ph_q       <= '0;
      chip_cnt_q <= '0;
      err_q      <= '0;
      phase_q    <= '0;
      lock_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
`ifdef DESPREAD_ERRCNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      win_q      <= win_d;
      ph_q       <= ph_d;
      chip_cnt_q <= chip_cnt_d;
      err_q      <= err_d;
      phase_q    <= phase_d;
      lock_q     <= lock_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
`ifdef DESPREAD_ERRCNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  // Output mapping.
  always_comb begin
    ready_o   = (state_q == StIdle);
    done_o    = done_q;
    lock_o    = lock_q;
    phase_o   = phase_q;
    abort_o   = abort_q;
`ifdef DESPREAD_ERRCNT_EN
    err_cnt_o = err_cnt_q;
`endif
  end

endmodule

// File: tb/tb_m_sequence_despreader.sv
// Bench for m_sequence_despreader: table of frames driven from a transmitter model, expected
// frame results pushed to a scoreboard and compared when done_o fires; hand-written abort and
// mid-frame reset sequences. A second instance with MAX_ERR=2 shares the stimulus.
module tb_m_sequence_despreader;

  localparam int unsigned N    = 63;
  localparam int unsigned HOLD = 3;
  localparam logic [5:0]  POLY = 6'b000011;

  logic       clkin = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       chip_i;
  logic       ready_o, done_o, lock_o, abort_o;
  logic [5:0] phase_o;
  logic       ready2, done2, lock2, abort2;
  logic [5:0] phase2;
`ifdef DESPREAD_ERRCNT_EN
  logic [5:0] err_cnt_o, err_cnt2;
`endif

  m_sequence_despreader #(.N(N), .POLYNOME(POLY), .HOLD(HOLD), .MAX_ERR(0)) dut (
    .clkin(clkin), .rst(rst), .valid_i(valid_i), .chip_i(chip_i),
    .ready_o(ready_o), .done_o(done_o), .lock_o(lock_o), .phase_o(phase_o), .abort_o(abort_o)
`ifdef DESPREAD_ERRCNT_EN
    , .err_cnt_o(err_cnt_o)
`endif
  );

  m_sequence_despreader #(.N(N), .POLYNOME(POLY), .HOLD(HOLD), .MAX_ERR(2)) dut2 (
    .clkin(clkin), .rst(rst), .valid_i(valid_i), .chip_i(chip_i),
    .ready_o(ready2), .done_o(done2), .lock_o(lock2), .phase_o(phase2), .abort_o(abort2)
`ifdef DESPREAD_ERRCNT_EN
    , .err_cnt_o(err_cnt2)
`endif
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] seed;
    int         fa;
    int         fb;
    bit         keep_valid;
    logic [5:0] exp_phase;
    logic       exp_lock;
    logic       exp_lock2;
    int         exp_err;
  } vec_t;

  typedef struct {
    logic [5:0] phase;
    logic       lock;
    logic       lock2;
    int         err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   abort_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives nchips chips of the transmitter sequence for v.seed, inverting chips v.fa / v.fb.
  task automatic send_frame(input vec_t v, input int nchips, input bit push);
    logic [5:0] s;
    logic       c;
    exp_t       e;
    s = v.seed;
    for (int k = 0; k < nchips; k++) begin
      c = s[0];
      if (k == v.fa || k == v.fb) c = ~c;
      s = {^(POLY & s), s[5:1]};
      for (int h = 0; h < int'(HOLD); h++) begin
        @(negedge clkin);
        if (k == 0 && h == 0) begin
          check("ready_before_frame", ready_o, 1);
          if (push) begin
            e.phase = v.exp_phase;
            e.lock  = v.exp_lock;
            e.lock2 = v.exp_lock2;
            e.err   = v.exp_err;
            e.cyc   = cyc + int'((N - 1) * HOLD) + 1;
            sb.push_back(e);
          end
        end
        if (k == 0 && h == 1) check("ready_low_in_frame", ready_o, 0);
        valid_i = 1'b1;
        chip_i  = c;
      end
    end
  endtask

  // Scoreboard consumer and unexpected-pulse watch.
  always @(negedge clkin) begin
    exp_t e;
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1, expected 0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("phase", phase_o, e.phase);
        check("lock", lock_o, e.lock);
        check("lock_maxerr2", lock2, e.lock2);
        check("phase_maxerr2", phase2, e.phase);
        check("done_maxerr2", done2, 1);
        check("ready_after_frame", ready_o, 1);
`ifdef DESPREAD_ERRCNT_EN
        check("err_cnt", err_cnt_o, e.err);
        check("err_cnt_maxerr2", err_cnt2, e.err);
`endif
      end
    end
    if (abort_o && !abort_ok) begin
      checks++;
      errors++;
      $display("FAIL unexpected_abort: got abort_o=1, expected 0 (t=%0t)", $time);
    end
  end

  vec_t vecs[4];
  vec_t v;

  initial begin
    // seed, flip a, flip b, keep valid, phase, lock(MAX_ERR=0), lock(MAX_ERR=2), errors
    vecs[0] = '{6'b101010, -1, -1, 1'b1, 6'b101010, 1'b1, 1'b1, 0};
    vecs[1] = '{6'b000111, -1, -1, 1'b0, 6'b000111, 1'b1, 1'b1, 0};
    vecs[2] = '{6'b000000, -1, -1, 1'b0, 6'b000000, 1'b0, 1'b0, 0};
    vecs[3] = '{6'b101010, 20, 40, 1'b0, 6'b101010, 1'b0, 1'b1, 2};

    rst = 1'b1;
    valid_i = 1'b0;
    chip_i = 1'b0;
    @(negedge clkin);
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_lock", lock_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_abort", abort_o, 0);
`ifdef DESPREAD_ERRCNT_EN
    check("rst_err_cnt", err_cnt_o, 0);
`endif
    @(negedge clkin);
    rst = 1'b0;
    repeat (2) @(negedge clkin);

    // vecs[0] keeps valid high, so vecs[1] follows back-to-back.
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i], N, 1'b1);
      if (!vecs[i].keep_valid) begin
        @(negedge clkin);
        valid_i = 1'b0;
        repeat (3) @(negedge clkin);
      end
    end

    // Abort: valid drops after chip 30; previous frame results must persist.
    v = '{6'b000111, -1, -1, 1'b0, 6'b000111, 1'b1, 1'b1, 0};
    send_frame(v, 31, 1'b0);
    @(negedge clkin);
    valid_i = 1'b0;
    abort_ok = 1'b1;
    @(negedge clkin);
    check("abort_pulse", abort_o, 1);
    check("abort_pulse_maxerr2", abort2, 1);
    check("abort_ready", ready_o, 1);
    check("abort_no_done", done_o, 0);
    check("abort_keep_lock", lock_o, 0);
    check("abort_keep_lock2", lock2, 1);
    check("abort_keep_phase", phase_o, 6'b101010);
    @(negedge clkin);
    check("abort_one_cycle", abort_o, 0);
    abort_ok = 1'b0;
    repeat (2) @(negedge clkin);

    // Reset in the middle of chip 45.
    send_frame(v, 46, 1'b0);
    #1;
    rst = 1'b1;
    valid_i = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1);
    check("midrst_done", done_o, 0);
    check("midrst_lock2", lock2, 0);
    check("midrst_phase", phase_o, 0);
    check("midrst_abort", abort_o, 0);
`ifdef DESPREAD_ERRCNT_EN
    check("midrst_err_cnt", err_cnt_o, 0);
`endif
    @(negedge clkin);
    @(negedge clkin);
    rst = 1'b0;
    repeat (2) @(negedge clkin);

    // Full frame after reset locks normally.
    v = '{6'b101010, -1, -1, 1'b0, 6'b101010, 1'b1, 1'b1, 0};
    send_frame(v, N, 1'b1);
    @(negedge clkin);
    valid_i = 1'b0;

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clkin);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d frames outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clkin);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
